// File: rtl/sm3_msg_padder.sv
// Streaming SM3 message padder: packs a byte-granular word stream into 512-bit
// blocks, appending the 0x80 marker, zero fill and 64-bit big-endian bit length.
module sm3_msg_padder #(
  parameter int IN_W  = 32,
  parameter int CNT_W = 61
) (
  input  logic                     io_mainClk,
  input  logic                     resetCtrl_systemReset,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IN_W-1:0]          in_data,
  input  logic                     in_last,
  input  logic [$clog2(IN_W/8):0]  in_bytes,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [511:0]             out_block,
  output logic                     out_first,
  output logic                     out_last,
  output logic                     busy
);

  localparam int WPB = 512 / IN_W;
  localparam int BPW = IN_W / 8;
  localparam int BW  = $clog2(BPW) + 1;
  localparam int IW  = $clog2(WPB);

  typedef enum logic [1:0] {FILL, EMIT, EMIT_LEN} state_t;

  state_t             state, state_nx;
  logic [511:0]       blk_p1;
  logic               first_p1, last_p1;
  logic               len_pend_p1, len_mark_p1;
  logic [63:0]        len_p1;
  logic [CNT_W-1:0]   cnt_q;
  logic [IW-1:0]      widx;
  logic               busy_q;

  logic [BW-1:0]      b_eff;
  logic [CNT_W-1:0]   cnt_nx;
  logic [5:0]         r;
  logic [IN_W-1:0]    wd;
  logic [511:0]       blk_fill;
  logic               mark_full, len_sep, fin, go_emit;

  // Saturate an over-range byte count to a full word.
  function automatic logic [BW-1:0] sat_bytes(input logic [BW-1:0] b);
    return (b > BW'(BPW)) ? BW'(BPW) : b;
  endfunction

  function automatic logic [63:0] bit_len(input logic [CNT_W-1:0] c);
    return 64'({c, 3'b000});
  endfunction

  // Stage p0: merge the incoming word into the block under construction
  always_comb begin
    b_eff  = in_last ? sat_bytes(in_bytes) : BW'(BPW);
    cnt_nx = cnt_q + CNT_W'(b_eff);
    r      = cnt_nx[5:0];
    wd     = '0;
    for (int k = 0; k < BPW; k++)
      if (BW'(k) < b_eff) wd[IN_W-1-8*k -: 8] = in_data[IN_W-1-8*k -: 8];
    blk_fill = blk_p1;
    for (int w = 0; w < WPB; w++) begin
      if (IW'(w) == widx)                blk_fill[511-IN_W*w -: IN_W] = wd;
      else if (in_last && IW'(w) > widx) blk_fill[511-IN_W*w -: IN_W] = '0;
    end
    // An exactly full block has no room for the marker; it moves to a length block.
    mark_full = in_last && (r == 6'd0) && (b_eff != '0);
    len_sep   = in_last && !mark_full && (r >= 6'd56);
    fin       = in_last && !mark_full && (r <= 6'd55);
    if (in_last && !mark_full) begin
      for (int j = 0; j < 64; j++)
        if (6'(j) == r) blk_fill[511-8*j -: 8] = 8'h80;
      if (r <= 6'd55) blk_fill[63:0] = bit_len(cnt_nx);
    end
    go_emit = in_last || (widx == IW'(WPB-1));
  end

  always_ff @(posedge io_mainClk) begin
    if (resetCtrl_systemReset || clear) state <= FILL;
    else                                state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid && go_emit) state_nx = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = len_pend_p1 ? EMIT_LEN : FILL;
      end
      EMIT_LEN: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  // Stage p1: block register presented to the compression core
  always_ff @(posedge io_mainClk) begin
    if (resetCtrl_systemReset || clear) begin
      blk_p1      <= '0;
      first_p1    <= 1'b1;
      last_p1     <= 1'b0;
      len_pend_p1 <= 1'b0;
      len_mark_p1 <= 1'b0;
      len_p1      <= '0;
      cnt_q       <= '0;
      widx        <= '0;
      busy_q      <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        blk_p1      <= blk_fill;
        cnt_q       <= cnt_nx;
        busy_q      <= 1'b1;
        widx        <= go_emit ? '0 : widx + 1'b1;
        last_p1     <= fin;
        len_pend_p1 <= mark_full || len_sep;
        len_mark_p1 <= mark_full;
        len_p1      <= bit_len(cnt_nx);
      end
      if (out_valid && out_ready) begin
        if (state == EMIT && len_pend_p1) begin
          blk_p1      <= {(len_mark_p1 ? 8'h80 : 8'h00), 440'b0, len_p1};
          first_p1    <= 1'b0;
          last_p1     <= 1'b1;
          len_pend_p1 <= 1'b0;
        end else begin
          first_p1 <= last_p1;
          if (last_p1) begin
            cnt_q   <= '0;
            widx    <= '0;
            busy_q  <= 1'b0;
            last_p1 <= 1'b0;
          end
        end
      end
    end
  end

  assign out_block = blk_p1;
  assign out_first = first_p1;
  assign out_last  = last_p1;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sm3_msg_padder.sv
// Directed bench for sm3_msg_padder: single-word table, multi-block sequences,
// back-pressure, soft clear, and a 64-bit input variant.
module tb_sm3_msg_padder;

  logic io_mainClk = 1'b0;
  always #5 io_mainClk = ~io_mainClk;

  logic         rst, clear;
  logic         in_valid, in_ready, in_last, out_valid, out_ready, out_first, out_last, busy;
  logic [31:0]  in_data;
  logic [2:0]   in_bytes;
  logic [511:0] out_block;

  logic         in_valid2, in_ready2, in_last2, out_valid2, out_ready2, out_first2, out_last2, busy2;
  logic [63:0]  in_data2;
  logic [3:0]   in_bytes2;
  logic [511:0] out_block2;

  int checks = 0;
  int failures = 0;

  sm3_msg_padder #(.IN_W(32), .CNT_W(61)) dut (
    .io_mainClk(io_mainClk), .resetCtrl_systemReset(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .in_bytes(in_bytes), .out_valid(out_valid), .out_ready(out_ready),
    .out_block(out_block), .out_first(out_first), .out_last(out_last), .busy(busy));

  sm3_msg_padder #(.IN_W(64), .CNT_W(61)) dut64 (
    .io_mainClk(io_mainClk), .resetCtrl_systemReset(rst), .clear(1'b0),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_last(in_last2),
    .in_bytes(in_bytes2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_block(out_block2), .out_first(out_first2), .out_last(out_last2), .busy(busy2));

  typedef struct {
    logic [31:0]  d;
    logic [2:0]   b;
    logic [511:0] exp;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic l, input logic [2:0] b);
    int t = 0;
    in_valid = 1'b1; in_data = d; in_last = l; in_bytes = b;
    while (!in_ready && t < 200) begin @(negedge io_mainClk); t++; end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL send_word: in_ready stuck at 0, expected 1");
    end
    @(negedge io_mainClk);
    in_valid = 1'b0;
  endtask

  task automatic get_block(output logic [511:0] b, output logic f, output logic l);
    int t = 0;
    while (!out_valid && t < 300) begin @(negedge io_mainClk); t++; end
    if (!out_valid) begin
      checks++; failures++;
      $display("FAIL get_block: out_valid stuck at 0, expected 1");
      b = '0; f = 1'b0; l = 1'b0;
    end else begin
      b = out_block; f = out_first; l = out_last;
      out_ready = 1'b1;
      @(negedge io_mainClk);
      out_ready = 1'b0;
    end
  endtask

  logic [511:0] b1, b2, exp1;
  logic         f1, l1, f2, l2;

  initial begin
    tbl[0] = '{32'h61626300, 3'd3, {32'h61626380, 416'b0, 64'h18}};
    tbl[1] = '{32'h00000000, 3'd0, {32'h80000000, 480'b0}};
    tbl[2] = '{32'hABCDEF12, 3'd1, {32'hAB800000, 416'b0, 64'h8}};
    tbl[3] = '{32'h01020304, 3'd4, {32'h01020304, 32'h80000000, 384'b0, 64'h20}};
    tbl[4] = '{32'hDEADBEEF, 3'd2, {32'hDEAD8000, 416'b0, 64'h10}};

    rst = 1'b1; clear = 1'b0;
    in_valid = 0; in_data = '0; in_last = 0; in_bytes = '0; out_ready = 0;
    in_valid2 = 0; in_data2 = '0; in_last2 = 0; in_bytes2 = '0; out_ready2 = 0;
    repeat (3) @(negedge io_mainClk);
    rst = 1'b0;
    @(negedge io_mainClk);

    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_block", out_block, 0);
    chk("rst_out_first", out_first, 1);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);

    // Single-word messages
    for (int i = 0; i < 5; i++) begin
      send_word(tbl[i].d, 1'b1, tbl[i].b);
      chk($sformatf("tbl%0d_latency", i), out_valid, 1);
      get_block(b1, f1, l1);
      chk($sformatf("tbl%0d_block", i), b1, tbl[i].exp);
      chk($sformatf("tbl%0d_first", i), f1, 1);
      chk($sformatf("tbl%0d_last", i), l1, 1);
      chk($sformatf("tbl%0d_busy_after", i), busy, 0);
    end

    // 64 bytes: data block then marker + length block
    fork
      for (int i = 0; i < 16; i++) send_word(32'h61626364, i == 15, 3'd4);
      begin get_block(b1, f1, l1); get_block(b2, f2, l2); end
    join
    chk("full_b1", b1, {16{32'h61626364}});
    chk("full_f1", f1, 1);
    chk("full_l1", l1, 0);
    chk("full_b2", b2, {32'h80000000, 416'b0, 64'h200});
    chk("full_f2", f2, 0);
    chk("full_l2", l2, 1);

    // 56 bytes: marker fits, length does not
    fork
      for (int i = 0; i < 14; i++) send_word(32'h11223344, i == 13, 3'd4);
      begin get_block(b1, f1, l1); get_block(b2, f2, l2); end
    join
    chk("b56_b1", b1, {{14{32'h11223344}}, 32'h80000000, 32'h0});
    chk("b56_l1", l1, 0);
    chk("b56_b2", b2, {448'b0, 64'h1C0});
    chk("b56_f2", f2, 0);
    chk("b56_l2", l2, 1);

    // 55 bytes: marker and length both fit
    fork
      for (int i = 0; i < 14; i++) send_word(32'h11223344, i == 13, (i == 13) ? 3'd3 : 3'd4);
      get_block(b1, f1, l1);
    join
    chk("b55_b1", b1, {{13{32'h11223344}}, 32'h11223380, 64'h1B8});
    chk("b55_f1", f1, 1);
    chk("b55_l1", l1, 1);

    // Back-pressure: hold out_ready low while the next word waits
    for (int i = 0; i < 16; i++) exp1[511-32*i -: 32] = 32'(i + 1);
    fork
      begin
        for (int i = 0; i < 16; i++) send_word(32'(i + 1), 1'b0, 3'd4);
        send_word(32'hAABBCCDD, 1'b1, 3'd2);
      end
      begin
        int t = 0;
        while (!out_valid && t < 100) begin @(negedge io_mainClk); t++; end
        chk("stall_valid", out_valid, 1);
        chk("stall_busy", busy, 1);
        for (int c = 0; c < 10; c++) begin
          chk("stall_block", out_block, exp1);
          chk("stall_in_ready", in_ready, 0);
          @(negedge io_mainClk);
        end
        chk("stall_first", out_first, 1);
        chk("stall_last", out_last, 0);
        out_ready = 1'b1;
        @(negedge io_mainClk);
        out_ready = 1'b0;
        get_block(b2, f2, l2);
      end
    join
    chk("stall_b2", b2, {32'hAABB8000, 416'b0, 64'h210});
    chk("stall_f2", f2, 0);
    chk("stall_l2", l2, 1);

    // Soft clear mid-message, with a word offered in the same cycle
    send_word(32'h01010101, 1'b0, 3'd4);
    send_word(32'h01010101, 1'b0, 3'd4);
    chk("clr_busy_before", busy, 1);
    in_valid = 1'b1; in_data = 32'h02020202; in_last = 1'b1; in_bytes = 3'd4; clear = 1'b1;
    @(negedge io_mainClk);
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_out_valid", out_valid, 0);
    chk("clr_out_block", out_block, 0);
    chk("clr_first", out_first, 1);
    send_word(32'h61626300, 1'b1, 3'd3);
    get_block(b1, f1, l1);
    chk("clr_abc_block", b1, {32'h61626380, 416'b0, 64'h18});
    chk("clr_abc_first", f1, 1);

    // 64-bit variant: "abc" in one word
    in_valid2 = 1'b1; in_data2 = 64'h6162630000000000; in_last2 = 1'b1; in_bytes2 = 4'd3;
    chk("w64_ready", in_ready2, 1);
    chk("w64_valid_before", out_valid2, 0);
    @(negedge io_mainClk);
    in_valid2 = 1'b0;
    chk("w64_valid_after", out_valid2, 1);
    chk("w64_block", out_block2, {32'h61626380, 416'b0, 64'h18});
    chk("w64_first", out_first2, 1);
    chk("w64_last", out_last2, 1);
    out_ready2 = 1'b1;
    @(negedge io_mainClk);
    out_ready2 = 1'b0;
    chk("w64_valid_done", out_valid2, 0);
    chk("w64_busy_done", busy2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
